// File: rtl/clk_mon_pkg.sv
// clk_mon_pkg: shared FSM encoding and default sizing for clock monitors
package clk_mon_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_LOW  = 2'd3;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_TIMEOUT = 200;
endpackage

// File: rtl/clk_sync_edge.sv
// clk_sync_edge: multi-flop synchronizer with registered-level rise/fall strobes
module clk_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] s;
  logic prev;
  always_ff @(posedge clk) begin
    if (reset) begin
      s <= '0;
      prev <= 1'b0;
    end else begin
      s <= {s[STAGES-2:0], d};
      prev <= s[STAGES-1];
    end
  end
  assign rise = s[STAGES-1] & ~prev;
  assign fall = ~s[STAGES-1] & prev;
endmodule

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures clk_in period/high time in clk cycles, flags mismatch, timeout, lock.
// CLK_PERIOD_METER_STICKY_EN: mismatch/timeout stay set until err_clr is pulsed.
module clk_period_meter
  import clk_mon_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TOL = 0,
  parameter int LOCK_CNT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clk_in,
  input  logic [CNT_W-1:0] expected_period,
`ifdef CLK_PERIOD_METER_STICKY_EN
  input  logic err_clr,
`endif
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic period_valid,
  output logic mismatch,
  output logic timeout,
  output logic locked
);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);
  localparam logic [GW-1:0] LOCK = GW'(LOCK_CNT);
  logic [1:0] state;
  logic [CNT_W-1:0] hi_cnt, lo_cnt, ph_cnt, per;
  logic [CNT_W:0] sum, diff;
  logic [GW-1:0] good_cnt, good_inc;
  logic rise, fall, rpt, bad, to_set, mis_nxt, to_nxt;
  clk_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .reset(reset),
    .d(clk_in),
    .rise(rise),
    .fall(fall)
  );
  assign sum = {1'b0, hi_cnt} + {1'b0, lo_cnt};
  assign per = sum[CNT_W] ? MAX : sum[CNT_W-1:0];
  assign diff = (per >= expected_period) ? {1'b0, per} - {1'b0, expected_period}
                                         : {1'b0, expected_period} - {1'b0, per};
  assign bad = diff > (CNT_W+1)'(TOL);
  assign rpt = (state == ST_LOW) && rise;
  // an edge arriving in the threshold cycle takes priority over the timeout
  assign to_set = (ph_cnt == TO) && (((state == ST_ARM) && !rise) ||
                                     ((state == ST_HIGH) && !fall) ||
                                     ((state == ST_LOW) && !rise));
  assign good_inc = (good_cnt == LOCK) ? LOCK : good_cnt + 1'b1;
`ifdef CLK_PERIOD_METER_STICKY_EN
  assign mis_nxt = (rpt && bad) || (mismatch && !err_clr);
  assign to_nxt = to_set || (timeout && !err_clr);
`else
  assign mis_nxt = rpt ? bad : mismatch;
  assign to_nxt = to_set || (timeout && !rise);
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      hi_cnt <= '0;
      lo_cnt <= '0;
      ph_cnt <= '0;
      good_cnt <= '0;
      period_out <= '0;
      high_out <= '0;
      period_valid <= 1'b0;
      mismatch <= 1'b0;
      timeout <= 1'b0;
      locked <= 1'b0;
    end else if (!enable) begin
      state <= ST_IDLE;
      hi_cnt <= '0;
      lo_cnt <= '0;
      ph_cnt <= '0;
      good_cnt <= '0;
      period_valid <= 1'b0;
      mismatch <= 1'b0;
      timeout <= 1'b0;
      locked <= 1'b0;
    end else begin
      period_valid <= rpt;
      mismatch <= mis_nxt;
      timeout <= to_nxt;
      if (rpt) begin
        period_out <= per;
        high_out <= hi_cnt;
      end
      if (to_set || (rpt && bad)) begin
        good_cnt <= '0;
        locked <= 1'b0;
      end else if (rpt) begin
        good_cnt <= good_inc;
        locked <= good_inc == LOCK;
      end
      if (to_set) begin
        state <= ST_ARM;
        hi_cnt <= '0;
        lo_cnt <= '0;
        ph_cnt <= '0;
      end else if (state == ST_IDLE) begin
        state <= ST_ARM;
        ph_cnt <= '0;
      end else if (((state == ST_ARM) || (state == ST_LOW)) && rise) begin
        state <= ST_HIGH;
        hi_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
        lo_cnt <= '0;
        ph_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
      end else if ((state == ST_HIGH) && fall) begin
        state <= ST_LOW;
        lo_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
        ph_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        hi_cnt <= ((state == ST_HIGH) && (hi_cnt != MAX)) ? hi_cnt + 1'b1 : hi_cnt;
        lo_cnt <= ((state == ST_LOW) && (lo_cnt != MAX)) ? lo_cnt + 1'b1 : lo_cnt;
        ph_cnt <= (ph_cnt != MAX) ? ph_cnt + 1'b1 : ph_cnt;
      end
    end
  end
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: directed checks of period, high time, mismatch, lock, timeout and enable/reset handling
module tb_clk_period_meter;
`ifdef CLK_PERIOD_METER_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic clk_in = 1'b0;
  logic err_clr = 1'b0;
  logic [7:0] expected_period = 8'd6;
  logic [7:0] p0, h0, p1, h1, p2, h2;
  logic v0, m0, t0, l0, v1, m1, t1, l1, v2, m2, t2, l2;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n0 = 0;
  int n1 = 0;
  logic [7:0] pa0 [256];
  logic [7:0] ha0 [256];
  logic ma0 [256];
  logic la0 [256];
  logic ma1 [256];
  int ca0 [256];

  always #5 clk = ~clk;

  clk_period_meter u0 (
    .clk(clk), .reset(reset), .enable(enable), .clk_in(clk_in), .expected_period(expected_period),
`ifdef CLK_PERIOD_METER_STICKY_EN
    .err_clr(err_clr),
`endif
    .period_out(p0), .high_out(h0), .period_valid(v0), .mismatch(m0), .timeout(t0), .locked(l0)
  );
  clk_period_meter #(.TOL(1)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .clk_in(clk_in), .expected_period(expected_period),
`ifdef CLK_PERIOD_METER_STICKY_EN
    .err_clr(err_clr),
`endif
    .period_out(p1), .high_out(h1), .period_valid(v1), .mismatch(m1), .timeout(t1), .locked(l1)
  );
  clk_period_meter #(.TIMEOUT(255)) u2 (
    .clk(clk), .reset(reset), .enable(enable), .clk_in(clk_in), .expected_period(expected_period),
`ifdef CLK_PERIOD_METER_STICKY_EN
    .err_clr(err_clr),
`endif
    .period_out(p2), .high_out(h2), .period_valid(v2), .mismatch(m2), .timeout(t2), .locked(l2)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (v0 && n0 < 256) begin
      pa0[n0] = p0;
      ha0[n0] = h0;
      ma0[n0] = m0;
      la0[n0] = l0;
      ca0[n0] = cyc;
      n0 = n0 + 1;
    end
    if (v1 && n1 < 256) begin
      ma1[n1] = m1;
      n1 = n1 + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wave(input int hi, input int lo, input int num);
    for (int k = 0; k < num; k++) begin
      clk_in = 1'b1;
      step(hi);
      clk_in = 1'b0;
      step(lo);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_per"}, p0, 0);
    check({tag, "_high"}, h0, 0);
    check({tag, "_pv"}, v0, 0);
    check({tag, "_mis"}, m0, 0);
    check({tag, "_to"}, t0, 0);
    check({tag, "_lock"}, l0, 0);
  endtask

  initial begin
    int b0, b1;
    step(3);
    check_zero("rst");
    reset = 1'b0;
    enable = 1'b1;
    step(2);
    b0 = n0;
    wave(3, 3, 6);
    check("a_cnt", n0 - b0, 5);
    for (int i = 0; i < 5; i++) begin
      check("a_per", pa0[b0+i], 6);
      check("a_high", ha0[b0+i], 3);
      check("a_mis", ma0[b0+i], 0);
      check("a_lock", la0[b0+i], (i >= 3) ? 1 : 0);
      if (i > 0) check("a_space", ca0[b0+i] - ca0[b0+i-1], 6);
    end
    check("a_lock1", l1, 1);
    expected_period = 8'd5;
    b0 = n0;
    b1 = n1;
    wave(3, 3, 5);
    check("b_cnt", n0 - b0, 5);
    check("b_cnt1", n1 - b1, 5);
    for (int i = 0; i < 5; i++) begin
      check("b_mis", ma0[b0+i], 1);
      check("b_lock", la0[b0+i], 0);
      check("b_mis1", ma1[b1+i], 0);
    end
    check("b_lock1", l1, 1);
    expected_period = 8'd6;
    b0 = n0;
    wave(3, 3, 5);
    check("c_cnt", n0 - b0, 5);
    check("c_lock3", la0[b0+2], 0);
    check("c_lock4", la0[b0+3], 1);
    check("c_mis", m0, STICKY);
    b0 = n0;
    clk_in = 1'b1;
    step(3);
    clk_in = 1'b0;
    step(202);
    check("d_to_early", t0, 0);
    check("d_lock_pre", l0, 1);
    step(1);
    check("d_to", t0, 1);
    check("d_lock_drop", l0, 0);
    check("d_to2", t2, 0);
    clk_in = 1'b1;
    step(4);
    check("d_to_clr", t0, STICKY);
    check("d_no_pv", n0 - b0, 1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    clk_in = 1'b0;
    step(3);
    wave(200, 200, 2);
    clk_in = 1'b1;
    step(5);
    check("e_per_sat", p2, 255);
    check("e_high", h2, 200);
    check("e_to", t2, 0);
    check("e_edge_wins_to", t0, 0);
    check("e_edge_wins_per", p0, 255);
    check("e_edge_wins_high", h0, 200);
    clk_in = 1'b0;
    step(3);
    wave(3, 3, 3);
    check("f_pre", p0, 6);
    clk_in = 1'b1;
    step(3);
    clk_in = 1'b0;
    step(5);
    b0 = n0;
    enable = 1'b0;
    step(1);
    check("f_lock", l0, 0);
    check("f_to", t0, 0);
    check("f_mis", m0, 0);
    step(1);
    check("f_hold", p0, 6);
    enable = 1'b1;
    step(3);
    wave(4, 4, 1);
    check("f_no_pv", n0 - b0, 0);
    check("f_hold2", p0, 6);
    clk_in = 1'b1;
    step(4);
    check("f_one_pv", n0 - b0, 1);
    check("f_per", p0, 8);
    check("f_high", h0, 4);
    clk_in = 1'b0;
    step(4);
    wave(3, 3, 6);
    clk_in = 1'b1;
    step(4);
    check("g_lock_pre", l0, 1);
    reset = 1'b1;
    step(1);
    check_zero("g_rst");
    reset = 1'b0;
`ifdef CLK_PERIOD_METER_STICKY_EN
    clk_in = 1'b0;
    step(3);
    expected_period = 8'd5;
    wave(3, 3, 3);
    check("s_mis_set", m0, 1);
    expected_period = 8'd6;
    wave(3, 3, 2);
    check("s_mis_hold", m0, 1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("s_mis_clr", m0, 0);
`endif
    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Receive-side counterpart of the programmable clock generator. It samples a generated pulse train (clk_in) on the system clock and measures its period and high time in system-clock cycles.
- Checks the measured period against an expected value, and flags mismatch, loss of clock (timeout) and lock.
- Sits beside the generator in clock benches and on-chip as a clock-health monitor.

Parameters:
- CNT_W, 8, width of period/high-time counters and outputs
- SYNC_STAGES, 2, synchronizer flops on clk_in (minimum 2)
- TIMEOUT, 200, max cycles in one phase before timeout (must be < 2^CNT_W)
- TOL, 0, allowed absolute period deviation (cycles) before mismatch
- LOCK_CNT, 4, consecutive in-tolerance periods required for lock

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  measurement enable
- clk_in  input  1  monitored pulse train (asynchronous to clk)
- expected_period  input  CNT_W  expected period in clk cycles
- period_out  output  CNT_W  last measured period
- high_out  output  CNT_W  last measured high time
- period_valid  output  1  one-cycle strobe: new period_out/high_out
- mismatch  output  1  last period outside expected_period±TOL
- timeout  output  1  no edge within TIMEOUT cycles
- locked  output  1  LOCK_CNT consecutive good periods seen

Behaviour:
- One clock domain (clk); reset is synchronous and active-high.
- Reset values:
  - period_out=0, high_out=0
  - period_valid=0, mismatch=0, timeout=0, locked=0
  - state=IDLE; synchronizer and counters cleared.
- Input path:
  - clk_in passes SYNC_STAGES flops, then a one-flop edge detector giving rise/fall strobes.
  - Detection latency is SYNC_STAGES+1 cycles after a clk_in transition.
- FSM states: IDLE, ARM, HIGH, LOW.
  - IDLE: enable=1 -> ARM.
  - ARM: discard partial period, wait for first rise -> HIGH. hi_cnt=1, lo_cnt=0 (the rise cycle counts as high).
  - HIGH: hi_cnt++ each cycle; on fall -> LOW with lo_cnt=1.
  - LOW: lo_cnt++ each cycle; on rise do the following in one cycle:
    - period_out=hi_cnt+lo_cnt, high_out=hi_cnt
    - period_valid=1 for exactly one cycle (registered, cycle after the rise strobe)
    - update mismatch/locked
    - restart HIGH with hi_cnt=1.
- Arithmetic:
  - Counters saturate at 2^CNT_W-1; no wrap.
  - Period sum is computed at CNT_W+1 bits and saturated to CNT_W.
- Compare:
  - mismatch = |period - expected_period| > TOL, unsigned, CNT_W+1 bits.
  - mismatch is updated only on period_valid and held between measurements.
- Lock:
  - Good-run counter increments on each in-tolerance period; locked=1 when it reaches LOCK_CNT, then saturates.
  - Any mismatch or timeout clears the counter and locked in the same cycle.
- Timeout:
  - In HIGH, LOW or ARM, a phase counter reaching TIMEOUT sets timeout=1 and locked=0, then goes to ARM.
  - timeout clears on the next detected rise.
- enable=0, any state:
  - next cycle -> IDLE; counters clear; locked=0, timeout=0, mismatch=0.
  - period_out/high_out hold their last values.
- Simultaneous events:
  - Rise and timeout threshold in the same cycle: the rise wins and the period is reported.
  - enable=0 overrides everything except reset.
- Reset mid-measurement: all state is lost; the first period after reset is never reported (ARM always discards).
- expected_period may change at any time; it is sampled in the compare cycle only.

Optional Feature:
- Macro CLK_PERIOD_METER_STICKY_EN.
- Defined:
  - mismatch and timeout are sticky: once set, they stay 1 until an added input port err_clr (1 bit) is pulsed.
  - err_clr in the same cycle as a new error: the error wins.
  - locked behaviour is unchanged.
- Undefined: flags behave as in Behaviour and the err_clr port is absent.

Decomposition:
- Shared package clk_mon_pkg:
  - FSM state encoding (IDLE=0, ARM=1, HIGH=2, LOW=3)
  - default CNT_W and TIMEOUT constants.
- One natural sub-module, clk_sync_edge: SYNC_STAGES synchronizer plus rise/fall strobe generation, reused by other monitors.
- Everything else is in clk_period_meter.

Test Plan:
- Generator-style stimulus, clk_in high 3 / low 3 cycles synchronous to clk, expected_period=6 -> period_valid strobes every 6 cycles with period_out=6, high_out=3, mismatch=0; locked=1 on the 4th strobe.
- Same stimulus with expected_period=5, TOL=0 -> mismatch=1 on every strobe, locked stays 0. With TOL=1 -> mismatch=0, locked after 4 strobes.
- clk_in held at 0 after lock, TIMEOUT=200 -> timeout=1 and locked=0 exactly 200 cycles after entering the phase. Next rise clears timeout; no period_valid for the broken period.
- High 200 / low 200, CNT_W=8, TIMEOUT=255 -> period_out saturates at 255, high_out=200, no timeout.
- enable dropped mid-LOW phase, then raised -> no period_valid for the interrupted period; the first report comes after two full rises; period_out holds its old value meanwhile.
- reset asserted mid-HIGH while locked -> next cycle all outputs 0, state IDLE. With STICKY_EN: force a mismatch, then 1 good period -> mismatch stays 1 until err_clr is pulsed.
